// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem read, 2-entry output queue to decode.
// Optional macro FETCH_HALT_EN: a fetched opcode 6'b111111 stops fetch until redirect/reset.
module fetch_unit #(
    parameter int unsigned INST_W   = 24,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [5:0]        opcode,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
`ifdef FETCH_HALT_EN
        , HALT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
    logic [1:0]          count_q, count_d;
    logic [INST_W-1:0]   h_inst_q, h_inst_d, t_inst_q, t_inst_d;
    logic [ADDR_W-1:0]   h_pc_q, h_pc_d, t_pc_q, t_pc_d;
    logic                issue, push, pop;
    logic [2:0]          occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= ADDR_W'(RESET_PC);
            req_pc_q <= '0;
            count_q  <= '0;
            h_inst_q <= '0;
            h_pc_q   <= '0;
            t_inst_q <= '0;
            t_pc_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            h_inst_q <= h_inst_d;
            h_pc_q   <= h_pc_d;
            t_inst_q <= t_inst_d;
            t_pc_q   <= t_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        h_inst_d = h_inst_q;
        h_pc_d   = h_pc_q;
        t_inst_d = t_inst_q;
        t_pc_d   = t_pc_q;
        issue    = 1'b0;
        push     = 1'b0;
        pop      = (count_q != 2'd0) && inst_ready;
        // Occupancy after this cycle's pop; an outstanding read adds one reserved slot.
        occ      = {1'b0, count_q} - {2'b00, pop};

        case (state_q)
            IDLE: begin
                if (occ < 3'd2) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push = 1'b1;
                    if (occ == 3'd0) issue = 1'b1;
                    else             state_d = IDLE;
`ifdef FETCH_HALT_EN
                    if (imem_rdata[INST_W-1 -: 6] == 6'h3F) begin
                        issue   = 1'b0;
                        state_d = HALT;
                    end
`endif
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: ;
        endcase

        if (redirect) begin
            issue   = 1'b0;
            push    = 1'b0;
            pc_d    = redirect_pc;
            // A read that returns in the redirect cycle is discarded here, so nothing is left to drop.
            state_d = ((state_q == WAIT || state_q == DROP) && !imem_rvalid) ? DROP : IDLE;
        end

        if (rst) issue = 1'b0;

        if (issue) begin
            pc_d     = pc_q + ADDR_W'(1);
            req_pc_d = pc_q;
        end

        if (redirect) begin
            count_d  = '0;
            h_inst_d = '0;
            h_pc_d   = '0;
            t_inst_d = '0;
            t_pc_d   = '0;
        end else if (push && pop) begin
            if (count_q == 2'd2) begin
                h_inst_d = t_inst_q;
                h_pc_d   = t_pc_q;
                t_inst_d = imem_rdata;
                t_pc_d   = req_pc_q;
            end else begin
                h_inst_d = imem_rdata;
                h_pc_d   = req_pc_q;
            end
        end else if (pop) begin
            h_inst_d = t_inst_q;
            h_pc_d   = t_pc_q;
            t_inst_d = '0;
            t_pc_d   = '0;
            count_d  = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                h_inst_d = imem_rdata;
                h_pc_d   = req_pc_q;
            end else begin
                t_inst_d = imem_rdata;
                t_pc_d   = req_pc_q;
            end
            count_d = count_q + 2'd1;
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = issue ? pc_q : '0;
    assign inst_valid = (count_q != 2'd0);
    assign inst       = h_inst_q;
    assign inst_pc    = h_pc_q;
    assign opcode     = h_inst_q[INST_W-1 -: 6];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;
    localparam int INST_W = 24;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid = 1'b0;
    logic [INST_W-1:0] imem_rdata = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b1;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [5:0]        opcode;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;

    logic              imem_req2;
    logic [ADDR_W-1:0] imem_addr2;
    logic              rvalid2 = 1'b0;
    logic [INST_W-1:0] rdata2 = '0;
    logic              inst_valid2;
    logic              ready2 = 1'b1;
    logic [INST_W-1:0] inst2;
    logic [ADDR_W-1:0] inst_pc2;
    logic [5:0]        opcode2;
    logic              redirect2 = 1'b0;
    logic [ADDR_W-1:0] redirect_pc2 = '0;

    always #5 clk = ~clk;

    fetch_unit #(.INST_W(INST_W), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.INST_W(INST_W), .ADDR_W(ADDR_W), .RESET_PC(1022)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2), .inst_valid(inst_valid2),
        .inst_ready(ready2), .inst(inst2), .inst_pc(inst_pc2), .opcode(opcode2),
        .redirect(redirect2), .redirect_pc(redirect_pc2)
    );

    int passed = 0;
    int total  = 0;

    int  lat      = 1;
    bit  halt_mem = 1'b0;
    int  cyc      = 0;
    int  viol     = 0;
    logic              mreq = 1'b0, mrst = 1'b1, pend = 1'b0, p2 = 1'b0;
    logic [ADDR_W-1:0] maddr = '0, pend_addr = '0, a2 = '0;
    int  cnt = 0;

    logic [ADDR_W-1:0] req_addr[$];
    int                req_cyc[$];
    logic [ADDR_W-1:0] dv_pc[$];
    logic [INST_W-1:0] dv_inst[$];
    logic [5:0]        dv_op[$];
    int                dv_cyc[$];
    logic [ADDR_W-1:0] req2[$];

    function automatic logic [INST_W-1:0] word(input logic [ADDR_W-1:0] a);
        if (halt_mem && a == 10'd3) return {6'h3F, 8'h00, a};
        return {14'h0000, a};
    endfunction

    // Sample the settled cycle on the falling edge.
    always @(negedge clk) begin
        mrst = rst;
        mreq = 1'b0;
        p2   = 1'b0;
        if (rst) begin
            cyc = 0;
        end else begin
            if (imem_req) begin
                if (pend) viol++;
                mreq = 1'b1;
                maddr = imem_addr;
                req_addr.push_back(imem_addr);
                req_cyc.push_back(cyc);
            end
            if (inst_valid && inst_ready) begin
                dv_pc.push_back(inst_pc);
                dv_inst.push_back(inst);
                dv_op.push_back(opcode);
                dv_cyc.push_back(cyc);
            end
            if (imem_req2) begin
                p2 = 1'b1;
                a2 = imem_addr2;
                req2.push_back(imem_addr2);
            end
            cyc++;
        end
    end

    // Memory responses change just after the rising edge.
    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mrst) begin
            pend = 1'b0;
        end else begin
            if (mreq) begin
                pend = 1'b1;
                pend_addr = maddr;
                cnt = lat;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(pend_addr);
                    pend = 1'b0;
                end
            end
        end
        rvalid2 = p2;
        rdata2  = {14'h0000, a2};
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inst_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        step(2);
        req_addr.delete(); req_cyc.delete();
        dv_pc.delete(); dv_inst.delete(); dv_op.delete(); dv_cyc.delete();
        req2.delete();
        viol = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect = 1'b0;
        inst_ready = 1'b1;
        step(3);
        total++;
        if ({imem_req, imem_addr, inst_valid, inst, inst_pc, opcode} !== '0)
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b inst=%h pc=%h op=%h, expected all 0",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, opcode);
        else passed++;
        total++;
        if ({imem_req2, imem_addr2, inst_valid2, inst2, inst_pc2, opcode2} !== '0)
            $display("FAIL reset_outputs_wrap: req=%b addr=%h valid=%b pc=%h, expected all 0",
                     imem_req2, imem_addr2, inst_valid2, inst_pc2);
        else passed++;
    endtask

    task automatic test_stream();
        lat = 1; halt_mem = 1'b0;
        do_reset();
        step(12);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= req_addr.size() || req_addr[i] !== 10'(i) || req_cyc[i] != i)
                $display("FAIL stream_req[%0d]: got %0d entries, addr=%h cyc=%0d; expected addr=%h cyc=%0d",
                         i, req_addr.size(), req_addr[i], req_cyc[i], 10'(i), i);
            else passed++;
            total++;
            if (i >= dv_pc.size() || dv_pc[i] !== 10'(i) || dv_cyc[i] != i + 2 || dv_inst[i] !== word(10'(i)))
                $display("FAIL stream_deliver[%0d]: pc=%h cyc=%0d inst=%h; expected pc=%h cyc=%0d inst=%h",
                         i, dv_pc[i], dv_cyc[i], dv_inst[i], 10'(i), i + 2, word(10'(i)));
            else passed++;
        end
    endtask

    task automatic test_latency3();
        lat = 3; halt_mem = 1'b0;
        do_reset();
        step(20);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= req_addr.size() || req_addr[i] !== 10'(i) || req_cyc[i] != 3 * i)
                $display("FAIL lat3_req[%0d]: addr=%h cyc=%0d; expected addr=%h cyc=%0d",
                         i, req_addr[i], req_cyc[i], 10'(i), 3 * i);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= dv_pc.size() || dv_pc[i] !== 10'(i) || dv_cyc[i] != 3 * i + 4)
                $display("FAIL lat3_deliver[%0d]: pc=%h cyc=%0d; expected pc=%h cyc=%0d",
                         i, dv_pc[i], dv_cyc[i], 10'(i), 3 * i + 4);
            else passed++;
        end
        total++;
        if (viol != 0) $display("FAIL lat3_overlap: %0d requests while outstanding, expected 0", viol);
        else passed++;
    endtask

    task automatic test_backpressure();
        lat = 1; halt_mem = 1'b0;
        do_reset();
        inst_ready = 1'b0;
        step(12);
        total++;
        if (req_addr.size() != 2) $display("FAIL bp_req_count: %0d requests, expected 2", req_addr.size());
        else passed++;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h000)
            $display("FAIL bp_head: valid=%b pc=%h, expected valid=1 pc=000", inst_valid, inst_pc);
        else passed++;
        inst_ready = 1'b1;
        step(6);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= dv_pc.size() || dv_pc[i] !== 10'(i) || dv_cyc[i] != 12 + i)
                $display("FAIL bp_deliver[%0d]: pc=%h cyc=%0d; expected pc=%h cyc=%0d",
                         i, dv_pc[i], dv_cyc[i], 10'(i), 12 + i);
            else passed++;
        end
        total++;
        if (req_addr.size() < 3 || req_addr[2] !== 10'h002 || req_cyc[2] != 12)
            $display("FAIL bp_resume: addr=%h cyc=%0d, expected addr=002 cyc=12", req_addr[2], req_cyc[2]);
        else passed++;
    endtask

    task automatic test_redirect_outstanding();
        lat = 3; halt_mem = 1'b0;
        do_reset();
        step(4);
        redirect = 1'b1; redirect_pc = 10'h100;
        step(1);
        redirect = 1'b0;
        total++;
        if (inst_valid !== 1'b0) $display("FAIL redir_flush: valid=%b, expected 0", inst_valid);
        else passed++;
        step(12);
        total++;
        if (req_addr.size() < 4 || req_addr[2] !== 10'h100 || req_cyc[2] != 7 || req_addr[1] !== 10'h001)
            $display("FAIL redir_req: req[1]=%h req[2]=%h cyc=%0d, expected 001, 100 at cyc 7",
                     req_addr[1], req_addr[2], req_cyc[2]);
        else passed++;
        total++;
        if (dv_pc.size() != 3 || dv_pc[0] !== 10'h000 || dv_pc[1] !== 10'h100 || dv_cyc[1] != 11 || dv_pc[2] !== 10'h101)
            $display("FAIL redir_deliver: n=%0d pcs=%h,%h,%h cyc1=%0d, expected n=3 pcs=000,100,101 cyc1=11",
                     dv_pc.size(), dv_pc[0], dv_pc[1], dv_pc[2], dv_cyc[1]);
        else passed++;
        total++;
        if (viol != 0) $display("FAIL redir_overlap: %0d requests while outstanding, expected 0", viol);
        else passed++;
    endtask

    task automatic test_redirect_same_cycle_data();
        lat = 1; halt_mem = 1'b0;
        do_reset();
        step(3);
        redirect = 1'b1; redirect_pc = 10'h100;
        step(1);
        redirect = 1'b0;
        total++;
        if (inst_valid !== 1'b0) $display("FAIL redir2_flush: valid=%b, expected 0", inst_valid);
        else passed++;
        step(4);
        total++;
        if (req_addr.size() < 4 || req_addr[3] !== 10'h100 || req_cyc[3] != 4 || req_cyc[2] != 2)
            $display("FAIL redir2_req: req[3]=%h cyc=%0d req_cyc[2]=%0d, expected 100 at cyc 4, prior at 2",
                     req_addr[3], req_cyc[3], req_cyc[2]);
        else passed++;
        total++;
        if (dv_pc.size() != 4 || dv_pc[1] !== 10'h001 || dv_cyc[1] != 3 || dv_pc[2] !== 10'h100 || dv_cyc[2] != 6)
            $display("FAIL redir2_deliver: n=%0d pc1=%h@%0d pc2=%h@%0d, expected n=4 001@3 100@6",
                     dv_pc.size(), dv_pc[1], dv_cyc[1], dv_pc[2], dv_cyc[2]);
        else passed++;
    endtask

    task automatic test_wrap();
        lat = 1; halt_mem = 1'b0;
        do_reset();
        step(4);
        total++;
        if (req2.size() < 3 || req2[0] !== 10'h3FE || req2[1] !== 10'h3FF || req2[2] !== 10'h000)
            $display("FAIL wrap_req: %h %h %h, expected 3fe 3ff 000", req2[0], req2[1], req2[2]);
        else passed++;
        total++;
        if (inst_valid2 !== 1'b1 || inst_pc2 !== 10'h000)
            $display("FAIL wrap_deliver: valid=%b pc=%h, expected valid=1 pc=000", inst_valid2, inst_pc2);
        else passed++;
    endtask

    task automatic test_halt_opcode();
        lat = 1; halt_mem = 1'b1;
        do_reset();
        step(10);
        total++;
        if (dv_pc.size() < 4 || dv_op[3] !== 6'h3F || dv_inst[3] !== {6'h3F, 8'h00, 10'h003})
            $display("FAIL op3f_deliver: op=%h inst=%h, expected op=3f inst=fc0003", dv_op[3], dv_inst[3]);
        else passed++;
`ifdef FETCH_HALT_EN
        total++;
        if (req_addr.size() != 4 || req_addr[3] !== 10'h003)
            $display("FAIL halt_stop: %0d requests, last=%h, expected 4 ending at 003",
                     req_addr.size(), req_addr[req_addr.size() - 1]);
        else passed++;
        redirect = 1'b1; redirect_pc = 10'h000;
        step(1);
        redirect = 1'b0;
        step(3);
        total++;
        if (req_addr.size() < 5 || req_addr[4] !== 10'h000 || req_cyc[4] != 11)
            $display("FAIL halt_restart: req[4]=%h cyc=%0d, expected 000 at cyc 11", req_addr[4], req_cyc[4]);
        else passed++;
`else
        total++;
        if (req_addr.size() < 5 || req_addr[4] !== 10'h004 || dv_pc.size() < 5 || dv_pc[4] !== 10'h004)
            $display("FAIL op3f_continue: req[4]=%h deliver[4]=%h, expected 004 and 004", req_addr[4], dv_pc[4]);
        else passed++;
`endif
        halt_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset();
        test_latency3();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_same_cycle_data();
        test_wrap();
        test_halt_opcode();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the control unit. It keeps the program counter and issues word reads to instruction memory. At most one read is outstanding at a time. Returned instructions are buffered in a 2-entry queue and presented to decode with a valid/ready handshake; `opcode` drives the control unit's opcode input directly. A redirect from execute flushes queued and in-flight instructions.

## Interface
- `INST_W`, 24: instruction width; opcode is `inst[INST_W-1 -: 6]`.
- `ADDR_W`, 10: word-address width of instruction memory.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  read request, one-cycle pulse per read.
- `imem_addr`  out  ADDR_W  word address, valid when `imem_req`=1.
- `imem_rvalid`  in  1  read data valid; arrives 1 or more cycles after `imem_req`.
- `imem_rdata`  in  INST_W  instruction word, valid when `imem_rvalid`=1.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst`  out  INST_W  head instruction; 0 when empty.
- `inst_pc`  out  ADDR_W  address of head instruction; 0 when empty.
- `opcode`  out  6  `inst[INST_W-1 -: 6]`; 0 (NOP) when empty.
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  ADDR_W  new fetch address, sampled when `redirect`=1.

## Operation
- Fetch FSM states:
  - IDLE: no read outstanding.
  - WAIT: read outstanding, its data will be kept.
  - DROP: read outstanding, its data will be discarded.
  - HALT: fetch stopped. Exists only with the macro below.
- Issue condition: `count + in_flight - pop < 2`, with in_flight=1 in WAIT/DROP. Issuing drives `imem_req`=1 and `imem_addr`=pc.
- IDLE: when the issue condition holds, issue and go to WAIT; pc advances by 1.
- WAIT, `imem_rvalid`=1: push {rdata, issued pc} into the queue.
  - If the issue condition (now with in_flight=0) still holds, issue in the same cycle and stay in WAIT.
  - Otherwise go to IDLE.
- DROP, `imem_rvalid`=1: discard the data and go to IDLE.
- Pop when `inst_valid & inst_ready`. Push and pop in the same cycle on a full queue is legal; the count is unchanged.
- `redirect`=1 (highest priority):
  - Queue flushed to empty; pc <= `redirect_pc`.
  - WAIT goes to DROP. DROP stays DROP. IDLE/HALT go to IDLE.
  - No issue in the redirect cycle.
  - A pop in the same cycle counts as a completed transfer.
  - An `imem_rvalid` in the same cycle is discarded. Next state is then IDLE, not DROP.
- pc arithmetic is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- Reset: pc=RESET_PC, state IDLE, queue empty, `imem_req`=0, `imem_addr`=0, `inst_valid`=0, `inst`/`inst_pc`/`opcode`=0. Any outstanding read is forgotten; the memory must not return data after `rst`.

## Timing
- `imem_req` is combinational from state/queue count/`inst_ready`/`redirect`. Queue outputs are registered.
- Push in cycle N gives `inst_valid`=1 in cycle N+1.
- With 1-cycle memory, reset released at cycle 0:
  - Requests in cycles 0,1,2… with addr 0,1,2…
  - `imem_rvalid` in cycles 1,2,3…
  - `inst_valid` from cycle 2, sustained at 1 instruction per cycle while `inst_ready`=1.
- Redirect in cycle R:
  - `inst_valid`=0 in R+1.
  - From IDLE: first request to `redirect_pc` in R+1.
  - From WAIT: first request in the cycle after the dropped `imem_rvalid`.
- `inst_ready`=0 with full queue: no request issues; the outstanding read completes into the slot reserved for it.

## Configuration
- `FETCH_HALT_EN` defined:
  - A pushed instruction with opcode 6'b111111 is enqueued normally (decodes as NOP), then the FSM enters HALT.
  - Any same-cycle issue is suppressed.
  - HALT issues no requests until `redirect` or `rst`.
- Undefined: HALT state absent; 6'b111111 is fetched like any other opcode.

## Test plan
- Reset then 1-cycle memory returning word=addr, `inst_ready`=1 → requests at 0,1,2…; `inst_pc` 0,1,2… from cycle 2, one per cycle, no gaps.
- 3-cycle memory latency → one request per 3 cycles; `imem_req` never asserted while a read is outstanding.
- `inst_ready`=0 for 10 cycles → queue holds exactly 2 entries (pc 0,1), no further requests. On release, pc 0,1 pop in order and fetch resumes at 2.
- Redirect to 0x100 while a read is outstanding → returning word discarded, `inst_valid`=0 next cycle, next request addr 0x100, first delivered `inst_pc`=0x100.
- RESET_PC=2^ADDR_W-2 → fetched addresses 0x3FE, 0x3FF, 0x000.
- With `FETCH_HALT_EN`: word at address 3 has opcode 111111 → addr 3 delivered, no request to 4. Redirect to 0 → fetch restarts at 0.
